// File: rtl/dac_pkg.sv
// Shared PWM DAC sizing. The upstream serial-to-parallel shifter uses the same
// constants, so the code width cannot diverge between the two blocks.
package dac_pkg;
  localparam int unsigned DAC_N   = 4;
  localparam int unsigned PERIOD  = 2**DAC_N;
  localparam int unsigned CNT_MAX = PERIOD - 1;
endpackage

// File: rtl/pwm_period_counter.sv
// PWM period counter: free-runs while enabled, parks at zero while idle, and
// flags the wrap edge plus a registered first-cycle-of-period pulse.
module pwm_period_counter
  import dac_pkg::*;
#(
  parameter int unsigned N = DAC_N
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [N-1:0] o_cnt,
  output logic [N-1:0] o_cnt_next,
  output logic         o_wrap,
  output logic         o_period_start
);

  localparam logic [N-1:0] CNT_TOP = {N{1'b1}};
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] r_cnt;
  logic         r_period_start;
  logic [N-1:0] w_cnt_next;
  logic         w_wrap;

  // Next count and wrap detect; the wrap is only meaningful while enabled.
  always_comb begin
    w_cnt_next = {N{1'b0}};
    w_wrap     = 1'b0;
    if (i_en) begin
      w_cnt_next = r_cnt + CNT_ONE;
      w_wrap     = (r_cnt == CNT_TOP);
    end else begin
      w_cnt_next = {N{1'b0}};
      w_wrap     = 1'b0;
    end
  end

  // Counter and period-start registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt          <= {N{1'b0}};
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_next;
      r_period_start <= i_en & (w_cnt_next == {N{1'b0}});
    end
  end

  assign o_cnt          = r_cnt;
  assign o_cnt_next     = w_cnt_next;
  assign o_wrap         = w_wrap;
  assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC back end: double-buffered code word (shadow -> duty) applied only at
// period boundaries or while idle, compared against the period counter.
module pwm_dac
  import dac_pkg::*;
#(
  parameter int unsigned N = DAC_N
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [N-1:0] i_din,
  output logic         o_pwm_out,
  output logic         o_period_start,
  output logic         o_pending
);

  logic [N-1:0] r_shadow;
  logic [N-1:0] r_duty;
  logic         r_pending;
  logic         r_pwm_out;

  logic [N-1:0] w_cnt;
  logic [N-1:0] w_cnt_next;
  logic         w_wrap;
  logic         w_transfer;
  logic [N-1:0] w_duty_next;
  logic         w_pending_next;

  pwm_period_counter #(.N(N)) u_counter (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_en           (i_en),
    .o_cnt          (w_cnt),
    .o_cnt_next     (w_cnt_next),
    .o_wrap         (w_wrap),
    .o_period_start (o_period_start)
  );

  // Transfer at the wrap while running, or immediately while idle; a load at
  // the same edge bypasses the shadow so the newest code is never lost.
  always_comb begin
    w_transfer     = i_en ? w_wrap : r_pending;
    w_duty_next    = r_duty;
    w_pending_next = r_pending;
    if (w_transfer) begin
      w_duty_next    = i_load ? i_din : r_shadow;
      w_pending_next = 1'b0;
    end else if (i_load) begin
      w_duty_next    = r_duty;
      w_pending_next = 1'b1;
    end else begin
      w_duty_next    = r_duty;
      w_pending_next = r_pending;
    end
  end

  // Buffer registers and the output compare, aligned with the counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow  <= {N{1'b0}};
      r_duty    <= {N{1'b0}};
      r_pending <= 1'b0;
      r_pwm_out <= 1'b0;
    end else begin
      if (i_load) begin
        r_shadow <= i_din;
      end else begin
        r_shadow <= r_shadow;
      end
      r_duty    <= w_duty_next;
      r_pending <= w_pending_next;
      r_pwm_out <= i_en & (w_cnt_next < w_duty_next);
    end
  end

  assign o_pwm_out = r_pwm_out;
  assign o_pending = r_pending;

endmodule
